// File: rtl/ct_ifu_sram59_ctrl.sv
// ---------------------------------------------------------------------------
// ct_ifu_sram59_ctrl
//
// Controller for a 512 x 59-bit single-port SRAM macro. It arbitrates one
// write port and one read port onto the macro. Writes have priority. A
// starvation counter forces a read grant after four stalled read cycles.
// Read data comes back on a two-stage registered response pipeline.
//
// Optional feature: when the macro CT_IFU_SRAM59_INIT_EN is defined, the
// array is first zeroed by a 512-entry sweep (the INIT state). Requests are
// not accepted until the sweep is finished. When the macro is undefined, the
// controller starts directly in RUN and the array contents are undefined
// until written.
//
// Ports
//   forever_cpuclk   : sole clock, rising edge
//   cpurst_b         : synchronous active-low reset
//   wr_req_*         : write request (idx 9b, data 59b, bitmask 59b, 1 = write)
//   wr_req_rdy       : write accepted when wr_req_vld & wr_req_rdy
//   rd_req_vld/idx   : read request
//   rd_req_rdy       : read accepted when rd_req_vld & rd_req_rdy
//   rd_resp_vld/data : read response, two cycles after accept, no back-pressure
//   init_done        : array ready, requests may be accepted
//   sram_a/cen/d/gwen/wen : macro port (cen, gwen, wen active-low)
//   sram_q           : macro read data, valid the cycle after a read access
// ---------------------------------------------------------------------------
module ct_ifu_sram59_ctrl #(
  parameter int DATA_W = 59,
  parameter int ADDR_W = 9
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              wr_req_vld,
  input  logic [ADDR_W-1:0] wr_req_idx,
  input  logic [DATA_W-1:0] wr_req_data,
  input  logic [DATA_W-1:0] wr_req_mask,
  output logic              wr_req_rdy,
  input  logic              rd_req_vld,
  input  logic [ADDR_W-1:0] rd_req_idx,
  output logic              rd_req_rdy,
  output logic              rd_resp_vld,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_cen,
  output logic [DATA_W-1:0] sram_d,
  output logic              sram_gwen,
  output logic [DATA_W-1:0] sram_wen,
  input  logic [DATA_W-1:0] sram_q
);

  localparam logic [2:0] STARVE_LIMIT = 3'd4;

`ifdef CT_IFU_SRAM59_INIT_EN
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;
  localparam state_t            RST_STATE = ST_INIT;
  localparam logic [ADDR_W-1:0] INIT_LAST = '1;
  localparam logic [ADDR_W-1:0] INIT_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};
  logic [ADDR_W-1:0] init_cnt_q;
`else
  typedef enum logic [0:0] {
    ST_RUN = 1'b1
  } state_t;
  localparam state_t RST_STATE = ST_RUN;
`endif

  // The counter holds at 7. Under normal operation it never passes 4,
  // because a pending read is granted as soon as it reaches the limit.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  state_t            state_q;
  state_t            state_nxt;
  logic [2:0]        starve_cnt_q;
  logic              run_p0;
  logic              starve_p0;
  logic              wr_acc_p0;
  logic              rd_acc_p0;
  logic              rd_stall_p0;
  logic              vld_p1;
  logic              vld_p2;
  logic [DATA_W-1:0] data_p2;

  // ---- p0: arbitration and macro access in the request cycle ----
  assign run_p0      = cpurst_b && (state_q == ST_RUN);
  assign starve_p0   = (starve_cnt_q >= STARVE_LIMIT) && rd_req_vld;
  assign wr_req_rdy  = run_p0 && !starve_p0;
  assign rd_req_rdy  = run_p0 && (starve_p0 || !wr_req_vld);
  assign wr_acc_p0   = wr_req_vld && wr_req_rdy;
  assign rd_acc_p0   = rd_req_vld && rd_req_rdy;
  assign rd_stall_p0 = rd_req_vld && run_p0 && !rd_req_rdy;
  assign init_done   = run_p0;

  always_comb begin
    state_nxt = state_q;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
`ifdef CT_IFU_SRAM59_INIT_EN
    if (state_q == ST_INIT) begin
      if (init_cnt_q == INIT_LAST) begin
        state_nxt = ST_RUN;
      end
      // The sweep drives the macro only outside reset, so the port stays
      // idle while cpurst_b is low.
      if (cpurst_b) begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = init_cnt_q;
      end
    end else
`endif
    if (wr_acc_p0) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~wr_req_mask;
      sram_a    = wr_req_idx;
      sram_d    = wr_req_data;
    end else if (rd_acc_p0) begin
      sram_cen  = 1'b0;
      sram_a    = rd_req_idx;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q      <= RST_STATE;
      starve_cnt_q <= '0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
`ifdef CT_IFU_SRAM59_INIT_EN
      init_cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      if (rd_acc_p0) begin
        starve_cnt_q <= '0;
      end else if (rd_stall_p0) begin
        starve_cnt_q <= sat_inc3(starve_cnt_q);
      end
      // ---- p1: macro output sram_q is valid in this cycle ----
      vld_p1 <= rd_acc_p0;
      // ---- p2: captured read data is presented as the response ----
      vld_p2 <= vld_p1;
`ifdef CT_IFU_SRAM59_INIT_EN
      if (state_q == ST_INIT) begin
        init_cnt_q <= init_cnt_q + INIT_STEP;
      end
`endif
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (vld_p1) begin
      data_p2 <= sram_q;
    end
  end

  // The data register has no reset. Gating it with the valid signal keeps
  // the response bus at zero whenever no response is presented.
  assign rd_resp_vld  = cpurst_b && vld_p2;
  assign rd_resp_data = rd_resp_vld ? data_p2 : '0;

endmodule

// File: tb/tb_ct_ifu_sram59_ctrl.sv
module tb_ct_ifu_sram59_ctrl;
  localparam int DW = 59;
  localparam int AW = 9;
`ifdef CT_IFU_SRAM59_INIT_EN
  localparam int SWEEP = 512;
`else
  localparam int SWEEP = 0;
`endif
  localparam logic [DW-1:0] ONES = '1;
  localparam logic [DW-1:0] D1   = 59'h7FF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] D2   = 59'h123_4567_89AB_CDEF;
  localparam logic [DW-1:0] D3   = 59'h5A5_A5A5_0F0F_3C3C;

  logic          forever_cpuclk = 1'b0;
  logic          cpurst_b;
  logic          wr_req_vld;
  logic [AW-1:0] wr_req_idx;
  logic [DW-1:0] wr_req_data;
  logic [DW-1:0] wr_req_mask;
  logic          wr_req_rdy;
  logic          rd_req_vld;
  logic [AW-1:0] rd_req_idx;
  logic          rd_req_rdy;
  logic          rd_resp_vld;
  logic [DW-1:0] rd_resp_data;
  logic          init_done;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic [DW-1:0] sram_d;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_q;

  always #5 forever_cpuclk = ~forever_cpuclk;

  ct_ifu_sram59_ctrl dut (
    .forever_cpuclk(forever_cpuclk),
    .cpurst_b      (cpurst_b),
    .wr_req_vld    (wr_req_vld),
    .wr_req_idx    (wr_req_idx),
    .wr_req_data   (wr_req_data),
    .wr_req_mask   (wr_req_mask),
    .wr_req_rdy    (wr_req_rdy),
    .rd_req_vld    (rd_req_vld),
    .rd_req_idx    (rd_req_idx),
    .rd_req_rdy    (rd_req_rdy),
    .rd_resp_vld   (rd_resp_vld),
    .rd_resp_data  (rd_resp_data),
    .init_done     (init_done),
    .sram_a        (sram_a),
    .sram_cen      (sram_cen),
    .sram_d        (sram_d),
    .sram_gwen     (sram_gwen),
    .sram_wen      (sram_wen),
    .sram_q        (sram_q)
  );

  // Behavioural macro: bit-masked write, read data registered one cycle later.
  logic [DW-1:0] mem [512];
  always @(posedge forever_cpuclk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  // Reference state: contents, which bits are known, pending responses.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic [DW-1:0] known;
  } resp_t;
  resp_t         q[$];
  logic [DW-1:0] ref_mem [512];
  logic [DW-1:0] known [512];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            stalls = 0;
  int            init_left = 0;
  logic          s_wa, s_ra, s_rv;
  logic [DW-1:0] s_rd;

  typedef struct {
    logic          wv;
    logic [AW-1:0] wi;
    logic [DW-1:0] wd;
    logic [DW-1:0] wm;
    logic          rv;
    logic [AW-1:0] ri;
    logic          ewa;
    logic          era;
    logic          erv;
    logic          ed;
    logic [DW-1:0] erd;
  } vec_t;
  vec_t tbl [17];

  function automatic vec_t mk(bit wv, int wi, logic [DW-1:0] wd, logic [DW-1:0] wm,
                              bit rv, int ri, bit ewa, bit era, bit erv, bit ed,
                              logic [DW-1:0] erd);
    vec_t v;
    v.wv = wv; v.wi = AW'(wi); v.wd = wd; v.wm = wm; v.rv = rv; v.ri = AW'(ri);
    v.ewa = ewa; v.era = era; v.erv = erv; v.ed = ed; v.erd = erd;
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd59();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, check settled outputs, advance model.
  task automatic step(input bit rn, input bit wv, input logic [AW-1:0] wi,
                      input logic [DW-1:0] wd, input logic [DW-1:0] wm,
                      input bit rv, input logic [AW-1:0] ri);
    bit ewa, era, ev;
    int a;
    @(negedge forever_cpuclk);
    cpurst_b = rn; wr_req_vld = wv; wr_req_idx = wi; wr_req_data = wd;
    wr_req_mask = wm; rd_req_vld = rv; rd_req_idx = ri;
    #1;
    s_wa = wv && wr_req_rdy; s_ra = rv && rd_req_rdy;
    s_rv = rd_resp_vld; s_rd = rd_resp_data;
    if (!rn) begin
      chk("rst_resp", {rd_resp_vld, rd_resp_data}, '0);
      chk("rst_rdy_done", {wr_req_rdy, rd_req_rdy, init_done}, '0);
      chk("rst_sram", {sram_a, sram_cen, sram_gwen, sram_wen, sram_d},
          {9'd0, 1'b1, 1'b1, ONES, {DW{1'b0}}});
      q.delete(); stalls = 0; init_left = SWEEP;
    end else begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("resp_vld", rd_resp_vld, ev);
      if (ev) begin
        chk("resp_data", rd_resp_data & q[0].known, q[0].data & q[0].known);
        void'(q.pop_front());
      end
      if (init_left > 0) begin
        a = SWEEP - init_left;
        chk("init_rdy_done", {wr_req_rdy, rd_req_rdy, init_done}, '0);
        chk("init_sram", {sram_a, sram_cen, sram_gwen, sram_wen, sram_d},
            {AW'(a), 1'b0, 1'b0, {DW{1'b0}}, {DW{1'b0}}});
        ref_mem[a] = '0; known[a] = ONES; init_left--;
      end else begin
        chk("init_done", init_done, 1'b1);
        ewa = wv && !(rv && stalls >= 4);
        era = rv && (!wv || stalls >= 4);
        chk("accept", {s_wa, s_ra}, {ewa, era});
        if (ewa)
          chk("wr_sram", {sram_a, sram_cen, sram_gwen, sram_wen, sram_d},
              {wi, 1'b0, 1'b0, ~wm, wd});
        else if (era)
          chk("rd_sram", {sram_a, sram_cen, sram_gwen, sram_wen}, {ri, 1'b0, 1'b1, ONES});
        else
          chk("idle_sram", {sram_a, sram_cen, sram_gwen, sram_wen, sram_d},
              {9'd0, 1'b1, 1'b1, ONES, {DW{1'b0}}});
        if (ewa) begin
          ref_mem[wi] = (ref_mem[wi] & ~wm) | (wd & wm);
          known[wi]   = known[wi] | wm;
        end
        if (era) begin
          q.push_back('{cyc + 2, ref_mem[ri], known[ri]});
          stalls = 0;
        end else if (rv) begin
          stalls++;
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic rnd_step(input bit rn);
    step(rn, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), rnd59(), rnd59(),
         1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));
  endtask

  initial begin
    tbl[0]  = mk(1, 5,  D1,   ONES,  0, 0,  1, 0, 0, 0, '0);
    tbl[1]  = mk(0, 0,  '0,   '0,    1, 5,  0, 1, 0, 0, '0);
    tbl[2]  = mk(0, 0,  '0,   '0,    0, 0,  0, 0, 0, 0, '0);
    tbl[3]  = mk(0, 0,  '0,   '0,    0, 0,  0, 0, 1, 1, D1);
    tbl[4]  = mk(1, 16, '0,   ONES,  0, 0,  1, 0, 0, 0, '0);
    tbl[5]  = mk(1, 16, ONES, 59'hFF, 0, 0, 1, 0, 0, 0, '0);
    tbl[6]  = mk(0, 0,  '0,   '0,    1, 16, 0, 1, 0, 0, '0);
    tbl[7]  = mk(0, 0,  '0,   '0,    0, 0,  0, 0, 0, 0, '0);
    tbl[8]  = mk(0, 0,  '0,   '0,    0, 0,  0, 0, 1, 1, 59'hFF);
    tbl[9]  = mk(1, 32, D2,   ONES,  1, 32, 1, 0, 0, 0, '0);
    tbl[10] = mk(0, 0,  '0,   '0,    1, 32, 0, 1, 0, 0, '0);
    tbl[11] = mk(0, 0,  '0,   '0,    0, 0,  0, 0, 0, 0, '0);
    tbl[12] = mk(0, 0,  '0,   '0,    0, 0,  0, 0, 1, 1, D2);
    tbl[13] = mk(1, 48, D3,   ONES,  1, 49, 1, 0, 0, 0, '0);
    tbl[14] = mk(0, 0,  '0,   '0,    1, 49, 0, 1, 0, 0, '0);
    tbl[15] = mk(0, 0,  '0,   '0,    0, 0,  0, 0, 0, 0, '0);
    tbl[16] = mk(0, 0,  '0,   '0,    0, 0,  0, 0, 1, 0, '0);
    for (int i = 0; i < 512; i++) begin
      ref_mem[i] = '0;
      known[i]   = '0;
    end
    cpurst_b = 1'b0; wr_req_vld = 1'b0; rd_req_vld = 1'b0;
    wr_req_idx = '0; wr_req_data = '0; wr_req_mask = '0; rd_req_idx = '0;

    repeat (3) rnd_step(1'b0);
`ifdef CT_IFU_SRAM59_INIT_EN
    // Requests held valid throughout the sweep must not be accepted.
    for (int k = 0; k < SWEEP; k++) step(1'b1, 1'b1, AW'(k), ONES, ONES, 1'b1, AW'(k));
`else
    idle(1);
    chk("release_rdy_done", {wr_req_rdy, rd_req_rdy, init_done}, 3'b111);
`endif

    for (int i = 0; i < 17; i++) begin
      step(1'b1, tbl[i].wv, tbl[i].wi, tbl[i].wd, tbl[i].wm, tbl[i].rv, tbl[i].ri);
      chk($sformatf("tbl%0d_wacc", i), s_wa, tbl[i].ewa);
      chk($sformatf("tbl%0d_racc", i), s_ra, tbl[i].era);
      chk($sformatf("tbl%0d_rvld", i), s_rv, tbl[i].erv);
      if (tbl[i].ed) chk($sformatf("tbl%0d_rdata", i), s_rd, tbl[i].erd);
    end

    // Write and read both valid every cycle: 4 stalls, then a read grant.
    idle(1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, AW'(64 + i), rnd59(), ONES, 1'b1, AW'(80 + i));
      chk("starve_rd_grant", s_ra, (i % 5) == 4);
      chk("starve_wr_grant", s_wa, (i % 5) != 4);
    end
    idle(3);

    repeat (800) rnd_step(1'b1);
    idle(3);

    // Reset with a read in flight: its response must never appear.
    step(1'b1, 1'b0, '0, '0, '0, 1'b1, 9'd5);
    chk("flight_rd_acc", s_ra, 1'b1);
    rnd_step(1'b0);
    rnd_step(1'b0);
`ifndef CT_IFU_SRAM59_INIT_EN
    idle(1);
    chk("rerelease_rdy_done", {wr_req_rdy, rd_req_rdy, init_done}, 3'b111);
`endif
    for (int k = 0; k < SWEEP + 4; k++) begin
      step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
      chk("flight_no_resp", s_rv, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ct_ifu_sram59_ctrl.md
CT_IFU_SRAM59_CTRL -- requirements
Module: ct_ifu_sram59_ctrl

Interface
REQ-001 SHALL have clock and reset: one clock, forever_cpuclk; reset cpurst_b is synchronous and active-low.
REQ-002 forever_cpuclk  in  1  sole clock; all state updates on rising edge.
REQ-003 cpurst_b  in  1  synchronous active-low reset.
REQ-004 wr_req_vld / wr_req_idx / wr_req_data / wr_req_mask  in  1/9/59/59  write request; mask bit 1 = write that bit.
REQ-005 wr_req_rdy  out  1  write accepted when vld & rdy in the same cycle.
REQ-006 rd_req_vld / rd_req_idx  in  1/9  read request.
REQ-007 rd_req_rdy  out  1  read accepted when vld & rdy in the same cycle.
REQ-008 rd_resp_vld / rd_resp_data  out  1/59  registered read response.
REQ-009 init_done  out  1  high once array is initialised; stays high until reset.
REQ-010 sram_a / sram_cen / sram_d / sram_gwen / sram_wen  out  9/1/59/1/59  macro port; cen, gwen, wen active-low.
REQ-011 sram_q  in  59  macro read data, valid the cycle after a read access.

Function
REQ-012 SHALL implement FSM with states INIT and RUN; INIT -> RUN after the write to index 511; RUN exits only on reset.
REQ-013 INIT: one write per cycle, sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0, sram_a = 9-bit counter 0..511, incrementing by 1.
REQ-014 init_done SHALL rise the cycle after the index-511 write; wr_req_rdy and rd_req_rdy SHALL be 0 throughout INIT.
REQ-015 RUN: at most one SRAM access per cycle; default priority write over read.
REQ-016 Write access: sram_cen=0, sram_gwen=0, sram_a=wr_req_idx, sram_d=wr_req_data, sram_wen=~wr_req_mask, all in the accept cycle.
REQ-017 Read access: sram_cen=0, sram_gwen=1, sram_wen=all 1, sram_a=rd_req_idx.
REQ-018 No access: sram_cen=1, sram_gwen=1, sram_wen=all 1; sram_a and sram_d SHALL be 0.
REQ-019 Read accepted cycle N: sram_q captured at N+1; rd_resp_vld=1 with rd_resp_data at N+2 for exactly one cycle; reads are fully pipelined, one per cycle.
REQ-020 Simultaneous write and read: write accepted and read stalled (rd_req_rdy=0), whether the indices differ or match; a stalled same-index read issued later SHALL return the newly written data.
REQ-021 Anti-starvation: 3-bit counter increments on every cycle rd_req_vld is high and stalled by a write; when it reaches 4, the next cycle grants read (wr_req_rdy=0, rd_req_rdy=1); counter clears on any read accept.
REQ-022 Response path SHALL not back-pressure; consumer must sink rd_resp_vld every cycle.

Reset
REQ-023 While cpurst_b=0: sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0, rd_resp_vld=0, rd_resp_data=0, init_done=0, both rdy=0.
REQ-024 Reset SHALL set state INIT (or RUN if macro absent), init counter 0, starvation counter 0, and clear the read pipeline.
REQ-025 Reset mid-INIT restarts the sweep at index 0; reset with a read in flight SHALL drop its response (no rd_resp_vld after reset).

Configuration
REQ-026 Macro CT_IFU_SRAM59_INIT_EN defined: INIT sweep per REQ-012..014 is compiled in.
REQ-027 Macro absent: no INIT state or counter; FSM reset state is RUN, init_done=1 from the first cycle after reset release, and array contents are undefined until written.

Verification
REQ-028 Reset release with macro defined -> 512 consecutive cycles with cen=0, gwen=0, wen=0, d=0, a=0..511; init_done=1 on cycle 513; rdy=0 until then.
REQ-029 RUN: write idx 0x05, data 0x7FF_FFFF_FFFF_FFFF, mask all 1; read idx 0x05 next cycle -> rd_resp_vld two cycles after read accept with data 0x7FF_FFFF_FFFF_FFFF.
REQ-030 Masked write idx 0x10, data all 1, mask 0x000_0000_0000_00FF over a zeroed entry; read -> 0x000_0000_0000_00FF.
REQ-031 Write and read both valid every cycle for 10 cycles -> read granted on every 5th cycle (4 stalls then grant), never two back-to-back write-only stretches longer than 4.
REQ-032 Read accepted, cpurst_b=0 the next cycle -> rd_resp_vld never asserts; with macro defined the sweep restarts at a=0.
REQ-033 Macro undefined: reset release -> init_done=1 and both rdy=1 in the first cycle after reset release.
